// File: rtl/nfc_pkg.sv
// Shared definitions for the NAND flash controller atomic-command primitives.
package nfc_pkg;

    // Bit position of the CA slot on the atomic-command bus
    localparam int unsigned CaCmdBit = 3;
    // Largest address-cycle burst a single request can carry
    localparam int unsigned MaxAddrBytes = 5;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StWeLow,
        StWeHigh,
        StHold,
        StDone
    } state_e;

    // Bytes to send: one command byte, or the address count saturated to MaxAddrBytes
    function automatic logic [2:0] num_bytes(input logic ca_select, input logic [2:0] num_m1);
        logic [3:0] n;
        n = {1'b0, num_m1} + 4'd1;
        if (ca_select) begin
            return 3'd1;
        end
        if (n > 4'(MaxAddrBytes)) begin
            return 3'(MaxAddrBytes);
        end
        return n[2:0];
    endfunction

endpackage

// File: rtl/nfc_atom_ca_latch_if.sv
// Request/completion handshake plus the SDR NAND pin group driven by the CA latch.
interface nfc_atom_ca_latch_if #(
    parameter int unsigned NumberOfWays = 4
);
    logic                    iStart;
    logic                    oReady;
    logic                    oLastStep;
    logic [NumberOfWays-1:0] iTargetWay;
    logic                    iCASelect;
    logic [39:0]             iCAData;
    logic [15:0]             iNumOfData;
    logic [NumberOfWays-1:0] oCE_n;
    logic                    oCLE;
    logic                    oALE;
    logic                    oWE_n;
    logic [7:0]              oDQ;
    logic                    oDQOE;

    // Command-level FSM side
    modport master (
        output iStart, iTargetWay, iCASelect, iCAData, iNumOfData,
        input  oReady, oLastStep, oCE_n, oCLE, oALE, oWE_n, oDQ, oDQOE
    );

    // CA latch side
    modport slave (
        input  iStart, iTargetWay, iCASelect, iCAData, iNumOfData,
        output oReady, oLastStep, oCE_n, oCLE, oALE, oWE_n, oDQ, oDQOE
    );
endinterface

// File: rtl/nfc_cycle_timer.sv
// Loadable down-counter; zero flags the final cycle of a timed interval.
module nfc_cycle_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [Width-1:0] load_value,
    output logic [Width-1:0] count,
    output logic             zero
);
    logic [Width-1:0] count_q;

    // Load on interval entry, otherwise count down and stop at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);
endmodule

// File: rtl/nfc_atom_ca_latch.sv
// Atomic command/address latch: turns one request into CLE/ALE-qualified WE# byte writes.
module nfc_atom_ca_latch
    import nfc_pkg::*;
#(
    parameter int unsigned NumberOfWays = 4,
    parameter int unsigned PulseLow     = 3,
    parameter int unsigned PulseHigh    = 3,
    parameter int unsigned HoldCycles   = 4
) (
    input  logic                      iSystemClock,
    input  logic                      iReset,
    nfc_atom_ca_latch_if.slave        bus
);
    state_e                  state_q, state_d;
    logic                    timer_load;
    logic [7:0]              timer_value;
    logic [7:0]              timer_count;
    logic                    timer_zero;
    logic [39:0]             shift_q;
    logic [2:0]              bytes_left_q;
    logic [NumberOfWays-1:0] way_q;
    logic                    cas_q;
    logic                    ready;
    logic                    accept;
    logic                    advance;
    logic                    next_byte;
    logic                    unused_num;

    assign unused_num = ^bus.iNumOfData[15:3];

    assign ready  = (state_q == StIdle) || (state_q == StDone);
    assign accept = bus.iStart && ready;
    // DQ moves to the next byte on entry to the last WE# high cycle
    assign advance   = (state_q == StWeHigh) && (timer_count == 8'd1) && (bytes_left_q != 3'd0);
    assign next_byte = (state_q == StWeHigh) && timer_zero && (bytes_left_q != 3'd0);

    nfc_cycle_timer #(
        .Width (8)
    ) u_timer (
        .clk        (iSystemClock),
        .rst_n      (iReset),
        .load       (timer_load),
        .load_value (timer_value),
        .count      (timer_count),
        .zero       (timer_zero)
    );

    // State register
    always_ff @(posedge iSystemClock or negedge iReset) begin
        if (!iReset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture, byte shift register and remaining-byte counter
    always_ff @(posedge iSystemClock or negedge iReset) begin
        if (!iReset) begin
            shift_q      <= '0;
            bytes_left_q <= '0;
            way_q        <= '1;
            cas_q        <= 1'b0;
        end else if (accept) begin
            shift_q      <= bus.iCAData;
            bytes_left_q <= num_bytes(bus.iCASelect, bus.iNumOfData[2:0]) - 3'd1;
            way_q        <= bus.iTargetWay;
            cas_q        <= bus.iCASelect;
        end else begin
            if (advance) begin
                shift_q <= {shift_q[31:0], 8'h00};
            end
            if (next_byte) begin
                bytes_left_q <= bytes_left_q - 3'd1;
            end
        end
    end

    // Next-state and interval timer loading
    always_comb begin
        state_d     = state_q;
        timer_load  = 1'b0;
        timer_value = '0;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StSetup;
            end
            StSetup: begin
                state_d     = StWeLow;
                timer_load  = 1'b1;
                timer_value = 8'(PulseLow - 1);
            end
            StWeLow: begin
                if (timer_zero) begin
                    state_d     = StWeHigh;
                    timer_load  = 1'b1;
                    timer_value = 8'(PulseHigh - 1);
                end
            end
            StWeHigh: begin
                if (timer_zero) begin
                    timer_load = 1'b1;
                    if (bytes_left_q != 3'd0) begin
                        state_d     = StWeLow;
                        timer_value = 8'(PulseLow - 1);
                    end else begin
                        state_d     = StHold;
                        timer_value = 8'(HoldCycles - 1);
                    end
                end
            end
            StHold: begin
                if (timer_zero) state_d = StDone;
            end
            StDone: begin
                state_d = accept ? StSetup : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Pin outputs decoded from the current state
    always_comb begin
        bus.oReady    = ready;
        bus.oLastStep = (state_q == StDone);
        bus.oCE_n     = '1;
        bus.oCLE      = 1'b0;
        bus.oALE      = 1'b0;
        bus.oWE_n     = 1'b1;
        bus.oDQ       = 8'h00;
        bus.oDQOE     = 1'b0;
        unique case (state_q)
            StSetup, StWeLow, StWeHigh: begin
                bus.oCE_n = way_q;
                bus.oCLE  = cas_q;
                bus.oALE  = ~cas_q;
                bus.oDQOE = 1'b1;
                bus.oDQ   = shift_q[39:32];
                bus.oWE_n = (state_q != StWeLow);
            end
            StHold: begin
                bus.oCE_n = way_q;
            end
            default: ;
        endcase
    end
endmodule
